// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared byte width and sequencer state encoding for the UART
//               loopback path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_W    = 8;
    localparam int c_state_w = 2;

    localparam logic [c_state_w-1:0] S_IDLE      = 2'd0;
    localparam logic [c_state_w-1:0] S_WAIT_BUSY = 2'd1;
    localparam logic [c_state_w-1:0] S_WAIT_IDLE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Circular byte buffer with registered count/empty/full.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [DATA_W-1:0]      i_wdata,
    input  logic                   i_pop,
    output logic [DATA_W-1:0]      o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_one      = c_cw'(1);
    localparam logic [c_cw-1:0] c_full_cnt = c_cw'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_cw-1:0]   r_count;
    logic [c_cw-1:0]   w_count_nxt;
    logic              r_empty;
    logic              r_full;
    logic              w_do_push;
    logic              w_do_pop;

    // A push at full is discarded even if a pop frees a slot on the same edge.
    assign w_do_push = i_push & ~r_full;
    assign w_do_pop  = i_pop & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + c_one;
            2'b01:   w_count_nxt = r_count - c_one;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_full_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = r_empty;
    assign o_full  = r_full;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_bridge
// Description : Buffers uart_rx bytes and launches uart_tx one frame at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_bridge #(
    parameter int DATA_W       = uart_pkg::DATA_W,
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      rx_data,
    input  logic                   rx_done,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [DATA_W-1:0]      tx_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    import uart_pkg::*;

    localparam int c_tmr_w = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(BUSY_TIMEOUT - 1);

    logic [c_state_w-1:0] r_state;
    logic [c_tmr_w-1:0]   r_timer;
    logic                 r_tx_start;
    logic [DATA_W-1:0]    r_tx_data;
    logic                 r_overflow;
    logic [DATA_W-1:0]    w_fifo_rdata;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_launch;

    assign w_launch = (r_state == S_IDLE) && !w_empty && !tx_busy;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (rx_done),
        .i_wdata (rx_data),
        .i_pop   (w_launch),
        .o_rdata (w_fifo_rdata),
        .o_count (count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_tx_data  <= w_fifo_rdata;
                        r_tx_start <= 1'b1;
                        r_timer    <= '0;
                        r_state    <= S_WAIT_BUSY;
                    end
                end
                // Give up on a transmitter that never acknowledges the launch.
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_IDLE;
                    end else if (r_timer == c_tmr_last) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (!tx_busy) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (rx_done && w_full) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign empty    = w_empty;
    assign full     = w_full;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo_bridge
// Description : Scoreboard bench for the rx-to-tx byte bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo_bridge;

    localparam int DATA_W       = 8;
    localparam int DEPTH        = 16;
    localparam int BUSY_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_done = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;

    logic        busy_force = 1'b0;
    logic        model_busy = 1'b0;
    logic        model_en   = 1'b1;
    logic        rand_busy  = 1'b0;
    int          busy_len   = 16;
    int          mdl_len;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    logic        prev_start = 1'b0;

    always #5 clk = ~clk;
    assign tx_busy = busy_force | model_busy;

    uart_rx_fifo_bridge #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit keep);
        rx_data = b;
        rx_done = 1'b1;
        if (keep) exp_q.push_back(b);
        tick();
        rx_done = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        int s = 0;
        while (s < 3 && n < 3000) begin
            tick();
            n++;
            if (exp_q.size() == 0 && !tx_busy && empty) s++;
            else s = 0;
        end
        check(name, (s >= 3), 1);
    endtask

    // uart_tx stand-in: busy rises the clock after a launch and holds for a frame.
    always begin
        @(negedge clk);
        if (tx_start && model_en) begin
            mdl_len = rand_busy ? int'($urandom_range(20, 4)) : busy_len;
            @(posedge clk);
            #1 model_busy = 1'b1;
            repeat (mdl_len) @(posedge clk);
            #1 model_busy = 1'b0;
        end
    end

    // Scoreboard monitor: every launch must carry the oldest pending byte.
    always @(negedge clk) begin
        if (!rst && tx_start) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL tx_byte: got %0h expected no launch", tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (tx_data !== mon_exp) begin
                    n_err++;
                    $display("FAIL tx_byte: got %0h expected %0h", tx_data, mon_exp);
                end
            end
            n_vec++;
            if (tx_busy || prev_start) begin
                n_err++;
                $display("FAIL tx_handshake: got busy=%0b prev_start=%0b expected 0 0",
                         tx_busy, prev_start);
            end
        end
        prev_start = tx_start;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] b;

        // Reset values
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);

        // Single byte: launch two clocks after rx_done
        push_byte(8'hA5, 1'b1);
        check("single_count1", count, 1);
        check("single_empty0", empty, 0);
        tick();
        check("single_tx_start", tx_start, 1);
        check("single_tx_data", tx_data, 8'hA5);
        check("single_count0", count, 0);
        check("single_empty1", empty, 1);
        wait_drain("single_drain");

        // Burst held off by busy transmitter
        busy_force = 1'b1;
        push_byte(8'h01, 1'b1);
        push_byte(8'h02, 1'b1);
        push_byte(8'h03, 1'b1);
        check("burst_count", count, 3);
        tick();
        tick();
        check("burst_no_start", tx_start, 0);
        check("burst_count_held", count, 3);
        busy_force = 1'b0;
        wait_drain("burst_drain");

        // Fill, overflow, clear, set-beats-clear
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        check("fill_no_ovf", overflow, 0);
        push_byte(8'h10, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 16);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_clear", overflow, 0);
        clr_ovf = 1'b1;
        push_byte(8'h11, 1'b0);
        clr_ovf = 1'b0;
        check("ovf_set_wins", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_clear2", overflow, 0);
        busy_len = 4;
        busy_force = 1'b0;
        wait_drain("fill_drain");

        // Streaming with random frame lengths to wrap the pointers
        rand_busy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (full && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) check("stream_full_wait", n, 0);
            b = 8'(i * 37 + 5);
            push_byte(b, 1'b1);
            tick();
            tick();
        end
        wait_drain("stream_drain");
        rand_busy = 1'b0;

        // Push on the launch edge keeps count steady
        busy_force = 1'b1;
        push_byte(8'hB1, 1'b1);
        push_byte(8'hB2, 1'b1);
        check("simul_pre_count", count, 2);
        busy_force = 1'b0;
        rx_data = 8'hB3;
        rx_done = 1'b1;
        exp_q.push_back(8'hB3);
        tick();
        rx_done = 1'b0;
        check("simul_count", count, 2);
        check("simul_tx_start", tx_start, 1);
        check("simul_tx_data", tx_data, 8'hB1);
        wait_drain("simul_drain");

        // Transmitter never acknowledges: 8-clock wait then next launch
        model_en = 1'b0;
        push_byte(8'hC1, 1'b1);
        push_byte(8'hC2, 1'b1);
        check("to_first_start", tx_start, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_start && n < 20);
        check("to_launch_gap", n, 9);
        wait_drain("to_drain");
        model_en = 1'b1;

        // Asynchronous reset flushes stored bytes
        busy_force = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'hD0 + 8'(i), 1'b0);
        check("rst_pre_count", count, 5);
        #3 rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_full", full, 0);
        check("arst_tx_start", tx_start, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        busy_force = 1'b0;
        repeat (20) tick();
        check("post_rst_empty", empty, 1);
        check("post_rst_count", count, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
